// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: converts single read/write commands from a local client
// into one AXI4 INCR burst at a time, streaming write data in and read data out,
// and reports completion with a one-cycle done pulse carrying the AXI response.
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clock,
    input  logic                  reset,

    // Command interface
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,

    // Write beat stream from the client
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    // Read beat stream to the client
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,

    // Completion report
    output logic                  done_valid,
    output logic                  done_write,
    output logic [1:0]            done_resp,

    // AXI write address channel
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    // AXI write data channel
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    // AXI write response channel
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    // AXI read address channel
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    // AXI read data channel
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0]            AXI_SIZE  = 3'($clog2(STRB_WIDTH));
    localparam logic [1:0]            BURST_INCR = 2'b01;
    localparam logic [1:0]            RESP_OKAY  = 2'b00;
    // Clears the byte-lane bits so every burst starts on a bus-word boundary.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRESP,
        RDATA
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic [1:0]            err_q;
    logic                  done_valid_q;
    logic                  done_write_q;

    // ID, read-last and B/R IDs are not needed: one transaction is in flight and
    // the beat counter, not rlast, decides when a read burst ends.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

    // Command side
    assign cmd_ready  = (state == IDLE);
    assign done_valid = done_valid_q;
    assign done_write = done_write_q;
    assign done_resp  = err_q;

    // Address channels are driven from registers captured at command acceptance
    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;

    // Write data passes straight through; the handshake is only opened after AW
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = wr_strb;
    assign m_axi_wlast  = (beat_cnt == 8'd0);
    assign m_axi_wvalid = (state == WDATA) && wr_valid;
    assign wr_ready     = (state == WDATA) && m_axi_wready;

    assign m_axi_bready = (state == WRESP);

    // Read data passes straight through to the client, which sets the pace
    assign rd_data      = m_axi_rdata;
    assign rd_last      = (beat_cnt == 8'd0);
    assign rd_valid     = (state == RDATA) && m_axi_rvalid;
    assign m_axi_rready = (state == RDATA) && rd_ready;

    // Transaction sequencer: command capture, address issue, beat counting,
    // sticky error capture and the registered completion pulse.
    // NOTE: every register here is assigned with <= so that all of them see the
    // pre-edge values of each other, exactly as the flops will in hardware.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            beat_cnt     <= '0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            err_q        <= RESP_OKAY;
            done_valid_q <= 1'b0;
            done_write_q <= 1'b0;
        end else begin
            done_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr & ADDR_MASK;
                        len_q     <= cmd_len;
                        beat_cnt  <= cmd_len;
                        err_q     <= RESP_OKAY;
                        awvalid_q <= cmd_write;
                        arvalid_q <= !cmd_write;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (awvalid_q && m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        state     <= WDATA;
                    end else if (arvalid_q && m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= RDATA;
                    end
                end
                WDATA: begin
                    if (m_axi_wvalid && m_axi_wready) begin
                        beat_cnt <= beat_cnt - 8'd1;
                        if (beat_cnt == 8'd0) begin
                            state <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        err_q        <= m_axi_bresp;
                        done_valid_q <= 1'b1;
                        done_write_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        beat_cnt <= beat_cnt - 8'd1;
                        if ((err_q == RESP_OKAY) && (m_axi_rresp != RESP_OKAY)) begin
                            err_q <= m_axi_rresp;
                        end
                        if (beat_cnt == 8'd0) begin
                            done_valid_q <= 1'b1;
                            done_write_q <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
